// File: rtl/c1581_par_pkg.sv
// rtl/c1581_par_pkg.sv - shared types and defaults for the 1581 parallel-cable bridge
package c1581_par_pkg;

    typedef enum logic [1:0] {H_IDLE, H_SETUP, H_STB} host_st_t;
    typedef enum logic {D_IDLE, D_PULSE} drv_st_t;

    localparam int DEF_SETUP_CYC = 4;
    localparam int DEF_STB_CYC   = 8;
    localparam int DEF_FLAG_CYC  = 8;
    localparam int SYNC_DEPTH    = 2;

endpackage

// File: rtl/c1581_par_pulse.sv
// rtl/c1581_par_pulse.sv - synchronised fall detect followed by a delayed, stretched low pulse
module c1581_par_pulse
    import c1581_par_pkg::*;
#(
    parameter int DELAY  = 4,
    parameter int WIDTH  = 8,
    parameter bit RETRIG = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic enable,
    input  logic pin_n,
    output logic pulse_n,
    output logic done,
    output logic busy_hit
);

    localparam int MAXC = (DELAY > WIDTH) ? DELAY : WIDTH;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] DLY_LD = CW'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CW-1:0] WID_LD = CW'(WIDTH - 1);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  prev;
    logic                  fall_q;
    host_st_t              st;
    logic [CW-1:0]         cnt;

    // Edge detection runs every clk, independent of ce and enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '1;
            prev   <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_DEPTH-2:0], pin_n};
            prev   <= sync[SYNC_DEPTH-1];
            fall_q <= prev & ~sync[SYNC_DEPTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= H_IDLE;
            cnt     <= '0;
            pulse_n <= 1'b1;
        end else if (!enable) begin
            st      <= H_IDLE;
            cnt     <= '0;
            pulse_n <= 1'b1;
        end else begin
            case (st)
                H_IDLE: begin
                    if (fall_q) begin
                        if (DELAY == 0) begin
                            st      <= H_STB;
                            cnt     <= WID_LD;
                            pulse_n <= 1'b0;
                        end else begin
                            st  <= H_SETUP;
                            cnt <= DLY_LD;
                        end
                    end
                end
                H_SETUP: begin
                    if (ce) begin
                        if (cnt == '0) begin
                            st      <= H_STB;
                            cnt     <= WID_LD;
                            pulse_n <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                H_STB: begin
                    if (RETRIG && fall_q) begin
                        cnt <= WID_LD;
                    end else if (ce) begin
                        if (cnt == '0) begin
                            st      <= H_IDLE;
                            pulse_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    st      <= H_IDLE;
                    pulse_n <= 1'b1;
                end
            endcase
        end
    end

    assign done     = enable && (st == H_STB) && ce && (cnt == '0) && !(RETRIG && fall_q);
    assign busy_hit = !RETRIG && enable && fall_q && (st != H_IDLE);

endmodule

// File: rtl/c1581_par_link.sv
// rtl/c1581_par_link.sv - host-side wired-AND bus and strobe bridge to the 1581 parallel port
module c1581_par_link
    import c1581_par_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int STB_CYC   = DEF_STB_CYC,
    parameter int FLAG_CYC  = DEF_FLAG_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       enable,
    input  logic [7:0] host_pb_i,
    input  logic       host_pc2_n,
    output logic [7:0] host_pb_o,
    output logic       host_flag_n,
    input  logic [7:0] drv_data_i,
    input  logic       drv_stb_i,
    output logic [7:0] drv_data_o,
    output logic       drv_stb_o,
    input  logic       ovr_clr,
    output logic       overrun,
    output logic [7:0] xfer_cnt
);

    logic [7:0] bus;
    logic       host_done;
    logic       host_busy;
    logic       drv_done;
    logic       drv_busy;
    logic       unused_drv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus <= 8'hFF;
        end else begin
            bus <= enable ? (host_pb_i & drv_data_i) : 8'hFF;
        end
    end

    assign host_pb_o  = bus;
    assign drv_data_o = bus;

    c1581_par_pulse #(
        .DELAY  (SETUP_CYC),
        .WIDTH  (STB_CYC),
        .RETRIG (1'b0)
    ) u_host (
        .clk      (clk),
        .rst      (reset),
        .ce       (ce),
        .enable   (enable),
        .pin_n    (host_pc2_n),
        .pulse_n  (drv_stb_o),
        .done     (host_done),
        .busy_hit (host_busy)
    );

    // Drive strobes retrigger the FLAG pulse and never count as overrun.
    c1581_par_pulse #(
        .DELAY  (0),
        .WIDTH  (FLAG_CYC),
        .RETRIG (1'b1)
    ) u_drv (
        .clk      (clk),
        .rst      (reset),
        .ce       (ce),
        .enable   (enable),
        .pin_n    (drv_stb_i),
        .pulse_n  (host_flag_n),
        .done     (drv_done),
        .busy_hit (drv_busy)
    );

    assign unused_drv = drv_done ^ drv_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun  <= 1'b0;
            xfer_cnt <= 8'h00;
        end else begin
            overrun <= host_busy | (overrun & ~ovr_clr);
            if (host_done) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_c1581_par_link.sv
// tb/tb_c1581_par_link.sv - directed self-checking bench for c1581_par_link
module tb_c1581_par_link;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       enable;
    logic [7:0] host_pb_i;
    logic       host_pc2_n;
    logic [7:0] host_pb_o;
    logic       host_flag_n;
    logic [7:0] drv_data_i;
    logic       drv_stb_i;
    logic [7:0] drv_data_o;
    logic       drv_stb_o;
    logic       ovr_clr;
    logic       overrun;
    logic [7:0] xfer_cnt;

    int n_chk;
    int n_fail;
    int cyc;
    bit ce_div4;

    c1581_par_link dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .enable      (enable),
        .host_pb_i   (host_pb_i),
        .host_pc2_n  (host_pc2_n),
        .host_pb_o   (host_pb_o),
        .host_flag_n (host_flag_n),
        .drv_data_i  (drv_data_i),
        .drv_stb_i   (drv_stb_i),
        .drv_data_o  (drv_data_o),
        .drv_stb_o   (drv_stb_o),
        .ovr_clr     (ovr_clr),
        .overrun     (overrun),
        .xfer_cnt    (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] pb;
        logic [7:0] dd;
        logic [7:0] exp;
    } bus_vec_t;

    bus_vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One active edge, then land on the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ce = ce_div4 ? (cyc % 4 == 0) : 1'b1;
    endtask

    task automatic do_strobe();
        host_pc2_n = 1'b0;
        step();
        step();
        host_pc2_n = 1'b1;
        for (int i = 0; i < 18; i++) step();
    endtask

    initial begin
        int first;
        int last;
        bit stayed_high;

        n_chk = 0; n_fail = 0; cyc = 0; ce_div4 = 1'b0;
        vt[0] = '{1'b1, 8'h5A, 8'hFF, 8'h5A};
        vt[1] = '{1'b1, 8'hFF, 8'hA5, 8'hA5};
        vt[2] = '{1'b1, 8'hF0, 8'h3C, 8'h30};
        vt[3] = '{1'b0, 8'h00, 8'h00, 8'hFF};
        vt[4] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vt[5] = '{1'b1, 8'h81, 8'h7E, 8'h00};
        vt[6] = '{1'b1, 8'hC3, 8'hE7, 8'hC3};

        // 1: reset values, then first bus sample
        reset = 1'b1; ce = 1'b1; enable = 1'b1; host_pb_i = 8'h00; drv_data_i = 8'h00;
        host_pc2_n = 1'b1; drv_stb_i = 1'b1; ovr_clr = 1'b0;
        step(); step();
        chk("t1_host_pb", host_pb_o, 8'hFF);
        chk("t1_drv_data", drv_data_o, 8'hFF);
        chk("t1_drv_stb", drv_stb_o, 1);
        chk("t1_flag", host_flag_n, 1);
        chk("t1_overrun", overrun, 0);
        chk("t1_xfer", xfer_cnt, 0);
        reset = 1'b0;
        step();
        chk("t1_bus_host", host_pb_o, 8'h00);
        chk("t1_bus_drv", drv_data_o, 8'h00);

        for (int i = 0; i < 7; i++) begin
            enable = vt[i].en; host_pb_i = vt[i].pb; drv_data_i = vt[i].dd;
            step();
            chk($sformatf("bus_host_%0d", i), host_pb_o, vt[i].exp);
            chk($sformatf("bus_drv_%0d", i), drv_data_o, vt[i].exp);
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // 2: host strobe timing with default parameters
        host_pb_i = 8'h5A; drv_data_i = 8'hFF; host_pc2_n = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            step();
            if (k == 0) chk("t2_bus", drv_data_o, 8'h5A);
            if (k >= 6 && k <= 15) chk($sformatf("t2_stb_e%0d", k), drv_stb_o, (k >= 7 && k <= 14) ? 0 : 1);
            if (k == 14) chk("t2_xfer_before", xfer_cnt, 0);
            if (k == 15) chk("t2_xfer_after", xfer_cnt, 1);
            host_pc2_n = (k + 1 < 8) ? 1'b0 : 1'b1;
        end

        // 3: retriggered FLAG pulse
        drv_stb_i = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            step();
            chk($sformatf("t3_flag_e%0d", k), host_flag_n, (k >= 3 && k <= 14) ? 0 : 1);
            drv_stb_i = ((k + 1 < 2) || (k + 1 == 4) || (k + 1 == 5)) ? 1'b0 : 1'b1;
        end
        chk("t3_overrun", overrun, 0);

        // 4a: second PC2 fall during setup is ignored but flagged
        host_pc2_n = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k >= 6) chk($sformatf("t4_stb_e%0d", k), drv_stb_o, (k >= 7 && k <= 14) ? 0 : 1);
            host_pc2_n = ((k + 1 < 2) || (k + 1 == 5) || (k + 1 == 6)) ? 1'b0 : 1'b1;
        end
        chk("t4_overrun", overrun, 1);
        chk("t4_xfer", xfer_cnt, 2);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t4_ovr_cleared", overrun, 0);

        // 4b: clear and set in the same clk, set wins
        host_pc2_n = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 6) chk("t4b_ovr_before", overrun, 0);
            if (k == 7) chk("t4b_ovr_set_wins", overrun, 1);
            host_pc2_n = ((k + 1 < 2) || (k + 1 == 4) || (k + 1 == 5)) ? 1'b0 : 1'b1;
            ovr_clr = (k + 1 == 7);
        end
        chk("t4b_xfer", xfer_cnt, 3);

        // 5: ce every fourth clk stretches delay and width only
        ce_div4 = 1'b1;
        first = -1; last = -1;
        host_pc2_n = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (drv_stb_o == 1'b0) begin
                if (first < 0) first = k;
                last = k;
            end
            host_pc2_n = (k + 1 < 2) ? 1'b0 : 1'b1;
        end
        n_chk++;
        if (first < 16 || first > 19) begin
            n_fail++;
            $display("FAIL t5_delay: stb fell at edge %0d expected 16..19", first);
        end
        chk("t5_width", last - first + 1, 32);
        ce_div4 = 1'b0;
        step();
        chk("t5_xfer", xfer_cnt, 4);

        // 6a: enable dropped during H_STB aborts without counting
        host_pc2_n = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 9) chk("t6_stb_low", drv_stb_o, 0);
            if (k == 10) begin
                chk("t6_stb_abort", drv_stb_o, 1);
                chk("t6_bus_float", host_pb_o, 8'hFF);
            end
            host_pc2_n = (k + 1 < 2) ? 1'b0 : 1'b1;
            if (k == 9) enable = 1'b0;
            if (k == 10) enable = 1'b1;
        end
        stayed_high = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (drv_stb_o != 1'b1) stayed_high = 1'b0;
        end
        chk("t6_no_restart", stayed_high, 1);
        chk("t6_xfer_held", xfer_cnt, 4);
        chk("t6_ovr_held", overrun, 1);

        // 6b: async reset mid-H_SETUP
        host_pb_i = 8'h5A; drv_data_i = 8'hFF;
        host_pc2_n = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step();
            host_pc2_n = (k + 1 < 2) ? 1'b0 : 1'b1;
        end
        chk("t6b_bus_pre", host_pb_o, 8'h5A);
        #2 reset = 1'b1;
        #1;
        chk("t6b_stb", drv_stb_o, 1);
        chk("t6b_xfer", xfer_cnt, 0);
        chk("t6b_bus", host_pb_o, 8'hFF);
        chk("t6b_ovr", overrun, 0);
        chk("t6b_flag", host_flag_n, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("t6b_no_pulse", xfer_cnt, 0);

        // 6c: xfer_cnt wraps 255 -> 0
        for (int i = 0; i < 255; i++) do_strobe();
        chk("t6c_xfer_ff", xfer_cnt, 8'hFF);
        do_strobe();
        chk("t6c_xfer_wrap", xfer_cnt, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/c1581_par_link.md
Name: c1581_par_link

Overview:
Host-side parallel-cable bridge between the C64 user port (CIA2 port B, PC2, FLAG) and the 1581 drive's parallel bus (par_data_*/par_stb_*).
- Models the wired-AND 8-bit data bus of the cable.
- Converts the host's PC2 handshake into a delayed, stretched drive strobe.
- Converts drive strobes into host FLAG pulses.
- Sits directly upstream/downstream of the drive's VIA parallel port; one instance per drive.

Parameters:
SETUP_CYC, 4, ce ticks between the detected host PC2 fall and the drive strobe assert (data setup time); must be ≥1.
STB_CYC, 8, ce ticks for which drv_stb_o is held low; must be ≥1.
FLAG_CYC, 8, ce ticks for which host_flag_n is held low; must be ≥1.

Ports:
clk  input  1  single clock, 16 MHz drive clock
reset  input  1  asynchronous, active-high reset
ce  input  1  timing enable for the delay/width counters
enable  input  1  cable attached; 0 = bridge idle, bus floats high
host_pb_i  input  8  CIA2 PB output value (1 where not driven)
host_pc2_n  input  1  CIA2 PC2 handshake output, active low
host_pb_o  output  8  bus value presented to CIA2 PB inputs
host_flag_n  output  1  to CIA2 FLAG, active low
drv_data_i  input  8  from drive par_data_o
drv_stb_i  input  1  from drive par_stb_o, active low
drv_data_o  output  8  to drive par_data_i
drv_stb_o  output  1  to drive par_stb_i, active low
ovr_clr  input  1  clears the overrun flag
overrun  output  1  sticky: host strobe arrived while the previous one was still in progress
xfer_cnt  output  8  completed host→drive strobes, wraps 255→0

Behaviour:
- Reset (async): host_pb_o=FF, drv_data_o=FF, drv_stb_o=1, host_flag_n=1, overrun=0, xfer_cnt=0, both FSMs idle. Synchroniser flops reset to 1.
- Synchronisers: host_pc2_n and drv_stb_i each pass through 2 flops. Fall detect = previous synced value 1 and current synced value 0. Evaluated every clk, not gated by ce.
- Bus: registered each clk: bus <= enable ? (host_pb_i & drv_data_i) : FF. host_pb_o = bus and drv_data_o = bus. Latency is 1 clk.
- Host FSM, states H_IDLE, H_SETUP, H_STB:
  - H_IDLE: on PC2 fall with enable=1, go to H_SETUP and load cnt = SETUP_CYC-1.
  - H_SETUP: on each ce, if cnt=0 go to H_STB and load cnt = STB_CYC-1; otherwise decrement cnt.
  - H_STB: drv_stb_o=0 (registered). On each ce, if cnt=0 go to H_IDLE, set drv_stb_o=1 and increment xfer_cnt; otherwise decrement cnt.
  - drv_stb_o is low only in H_STB.
  - A PC2 fall while in H_SETUP or H_STB is ignored for sequencing and sets overrun.
- Drive FSM, states D_IDLE, D_PULSE:
  - D_IDLE: on drv_stb fall with enable=1, go to D_PULSE with host_flag_n=0 and load cnt = FLAG_CYC-1.
  - D_PULSE: on each ce, if cnt=0 go to D_IDLE with host_flag_n=1; otherwise decrement cnt.
  - A new drv_stb fall during D_PULSE reloads cnt (retrigger). It does not set overrun.
- Timing with ce=1 constantly:
  - drv_stb_o falls exactly 3+SETUP_CYC clk edges after the edge at which host_pc2_n is first sampled low, and stays low STB_CYC clks.
  - host_flag_n falls 3 clk edges after drv_stb_i is first sampled low.
- ce gaps stretch the delay and width counts only. Edge detection still runs every clk.
- The two FSMs are independent. Simultaneous host and drive events are both serviced in the same clk.
- overrun: set-dominant. If set and ovr_clr occur in the same clk, overrun=1.
- enable 1→0 mid-operation: next clk both FSMs go idle, drv_stb_o=1, host_flag_n=1, counters cleared; xfer_cnt is not incremented for the aborted strobe. xfer_cnt and overrun are held.
- enable 0→1: bus restarts; no spurious edge is generated because the synchronisers keep tracking inputs while disabled.

Decomposition:
- Package c1581_par_pkg holds:
  - host_st_t (H_IDLE, H_SETUP, H_STB) and drv_st_t (D_IDLE, D_PULSE)
  - default SETUP_CYC/STB_CYC/FLAG_CYC constants
  - sync depth constant = 2
- Sub-module c1581_par_pulse: synchroniser, fall detector, delay counter and width counter, with parameters DELAY, WIDTH, RETRIG.
  - Host path: DELAY=SETUP_CYC, WIDTH=STB_CYC, RETRIG=0; exposes a busy_hit output that drives overrun.
  - Drive path: DELAY=0 (skips the setup state), WIDTH=FLAG_CYC, RETRIG=1.

Test Plan:
1. Reset with host_pb_i=00, drv_data_i=00, then release → all outputs at reset values; after 1 clk, host_pb_o=drv_data_o=00.
2. enable=1, ce=1, host_pb_i=5A, drv_data_i=FF, PC2 low 8 clks → drv_data_o=5A from next clk; drv_stb_o low on clk edges 7..14 after PC2 sampled low (defaults); xfer_cnt 0→1.
3. Drive pulses drv_stb_i low 2 clks, repeats 4 clks later → host_flag_n low from edge 3, retriggered, 12 consecutive clks; overrun stays 0.
4. Second PC2 fall 5 clks after the first → single drv_stb_o pulse, overrun=1, xfer_cnt+1 only; ovr_clr and a new fall in the same clk → overrun stays 1.
5. ce every 4th clk → drv_stb_o delay and width are 4× default (±3 clk phase); edge still detected on a 2-clk PC2 pulse.
6. enable dropped during H_STB, and reset asserted mid-H_SETUP → drv_stb_o=1 next clk, no xfer_cnt increment; async reset forces outputs immediately; xfer_cnt=FF then one strobe → 00.
